i3c_table_arbiter: RTL and testbench
====================================

Name: i3c_table_arbiter

Overview:
- Arbitrates one single-port table memory (DAT or DCT storage) between two requesters: the hardware command-flow FSM ("hw") and the CSR/software access path ("sw").
- Serialises accesses, one at a time, and handles fixed memory read latency.
- Returns read data or write completion to the requester that issued the access.
- Sits between the table storage and its two clients. DAT uses DataWidth=64; DCT uses DataWidth=128.

Parameters:
- Depth, 32: number of table entries.
- DataWidth, 64: entry width in bits.
- MemLatency, 1: cycles from mem_req_o to mem_rdata_i valid; legal range 1..4.
- StarveLimit, 4: consecutive hw grants tolerated while sw is waiting.
- IdxW, $clog2(Depth): index width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- hw_req_i  in  1  hw access request; held until hw_gnt_o.
- hw_we_i  in  1  1=write, 0=read.
- hw_index_i  in  IdxW  entry index.
- hw_wdata_i  in  DataWidth  write data.
- hw_gnt_o  out  1  one-cycle grant pulse.
- hw_rvalid_o  out  1  one-cycle completion pulse (reads and writes).
- hw_rdata_o  out  DataWidth  read data, registered.
- sw_req_i, sw_we_i, sw_index_i, sw_wdata_i, sw_gnt_o, sw_rvalid_o, sw_rdata_o: same as hw_* for the sw requester.
- mem_req_o  out  1  memory access strobe.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  IdxW  memory address.
- mem_wdata_o  out  DataWidth  memory write data.
- mem_rdata_i  in  DataWidth  memory read data.
- busy_o  out  1  high in any state other than Idle.
- err_idx_o  out  1  one-cycle pulse on an out-of-range index.

Behaviour:
- Reset (clk and rst_n as already decided): clk is the clock; rst_n is an asynchronous, active-low reset. During reset, state=Idle and every output is 0, including rdata_o, starvation counter and round-robin pointer. A reset mid-access abandons the access; any late mem_rdata_i is ignored.
- States: Idle, Issue, Wait, Done.
- Arbitration runs in Idle and Done when any req_i is high:
  - Winner latched: owner, we, index, wdata.
  - Next state Issue. With no request, Done goes to Idle.
- Default policy:
  - hw has priority.
  - If sw_req_i is high and the starvation counter equals StarveLimit, sw wins.
  - Counter increments on each hw grant while sw_req_i is high.
  - Counter clears on a sw grant or whenever sw_req_i is low; it saturates at StarveLimit.
- Issue, cycle T:
  - owner gnt_o=1.
  - mem_req_o=1; mem_we_o/mem_addr_o/mem_wdata_o come from the latched values.
  - mem_* outputs are 0 outside Issue.
  - Write goes to Done. Read goes to Wait with latency counter = MemLatency-1, or straight to Done-capture when MemLatency=1.
- Wait: decrement the counter each cycle. mem_rdata_i is sampled at T+MemLatency into the owner's rdata register, then the state goes to Done.
- Done:
  - Owner rvalid_o=1: at T+MemLatency+1 for reads, T+1 for writes.
  - The non-owner's rdata_o is unchanged.
  - Each rdata_o holds until its own next read completes.
- Out-of-range index (index >= Depth, non-power-of-2 Depth only):
  - In Issue: gnt_o=1, mem_req_o=0, err_idx_o=1.
  - Next cycle Done: rvalid_o=1 with rdata_o=0 for a read; rdata_o unchanged for a write.
- Requester protocol:
  - req/we/index/wdata must be held stable from req rise through gnt; the latched copy taken at arbitration is used.
  - A requester drops req after gnt. If req is still high in the Done cycle, it is treated as a new request.
- Back-to-back:
  - Done→Issue is allowed, giving a write throughput of 1 access per 2 cycles.
  - Simultaneous hw and sw requests in Idle: hw granted first (default policy); sw is granted from the following Done.
- busy_o = (state != Idle).

Optional Feature:
- Macro: I3C_TABLE_ARB_RR_EN.
- Defined:
  - Round-robin policy. A 1-bit last-owner register is updated on every grant.
  - On contention the requester that was not last granted wins; a single requester always wins.
  - The starvation counter and StarveLimit are unused (counter logic not generated).
- Undefined: hw priority with starvation guard, as above.

Test Plan:
1. Reset, then hw read of index 5, memory entry 5 = 64'hDEAD_BEEF_0000_0005, MemLatency=1 → hw_gnt_o at T; mem_req_o=1, mem_addr_o=5 at T; hw_rvalid_o at T+2 with hw_rdata_o=64'hDEAD_BEEF_0000_0005; sw_rvalid_o stays 0.
2. sw write of index 3, data 64'h1234, then sw read of index 3 → first sw_rvalid_o at T+1; read returns 64'h1234; hw_rdata_o unchanged.
3. hw and sw both assert a read in the same Idle cycle → hw_gnt_o first, sw_gnt_o in the cycle after hw's Done. With I3C_TABLE_ARB_RR_EN defined and last owner = hw: sw is granted first.
4. sw_req_i held high while hw issues 6 back-to-back reads, StarveLimit=4 → grant order hw,hw,hw,hw,sw,hw,hw; counter back to 0 after the sw grant.
5. MemLatency=3, Depth=24, hw read of index 30 → err_idx_o pulse, no mem_req_o, hw_rvalid_o at T+1 with rdata=0. A following read of index 7 completes at T'+4.
6. rst_n asserted during Wait of a read → all outputs 0 immediately, state Idle; no rvalid pulse after release even though mem_rdata_i toggles.

Source files
------------

// File: rtl/i3c_table_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : i3c_table_arbiter
// Purpose  : Serialises hw/sw accesses to one single-port DAT/DCT table with
//            fixed read latency; define I3C_TABLE_ARB_RR_EN for round-robin.
// Revision : 1.0
// ============================================================================
module i3c_table_arbiter #(
    parameter int DEPTH        = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4,
    parameter int IDX_W        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hw_req_i,
    input  logic                  hw_we_i,
    input  logic [IDX_W-1:0]      hw_index_i,
    input  logic [DATA_WIDTH-1:0] hw_wdata_i,
    output logic                  hw_gnt_o,
    output logic                  hw_rvalid_o,
    output logic [DATA_WIDTH-1:0] hw_rdata_o,
    input  logic                  sw_req_i,
    input  logic                  sw_we_i,
    input  logic [IDX_W-1:0]      sw_index_i,
    input  logic [DATA_WIDTH-1:0] sw_wdata_i,
    output logic                  sw_gnt_o,
    output logic                  sw_rvalid_o,
    output logic [DATA_WIDTH-1:0] sw_rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [IDX_W-1:0]      mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  busy_o,
    output logic                  err_idx_o
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] c_LAT_INIT = 2'(MEM_LATENCY - 1);

    state_t                r_state, w_state_nxt;
    logic                  r_owner;          // 1 = sw owns the current access
    logic                  r_we;
    logic [IDX_W-1:0]      r_index;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [1:0]            r_lat;
    logic [DATA_WIDTH-1:0] r_hw_rdata, r_sw_rdata;
    logic                  w_arb, w_pick_sw, w_oob, w_issue, w_capture;

    assign w_arb     = ((r_state == S_IDLE) || (r_state == S_DONE)) && (hw_req_i || sw_req_i);
    assign w_issue   = (r_state == S_ISSUE);
    assign w_capture = (r_state == S_WAIT) && (r_lat == 2'd0);

    // Only a non-power-of-2 table can be addressed past its end.
    generate
        if ((2 ** IDX_W) != DEPTH) begin : g_oob
            assign w_oob = ({1'b0, r_index} >= (IDX_W + 1)'(DEPTH));
        end else begin : g_no_oob
            assign w_oob = 1'b0;
        end
    endgenerate

`ifdef I3C_TABLE_ARB_RR_EN
    logic r_last_sw;

    assign w_pick_sw = sw_req_i && (!hw_req_i || !r_last_sw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_sw <= 1'b0;
        end else if (w_issue) begin
            r_last_sw <= r_owner;
        end
    end
`else
    localparam int                 c_STV_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_STV_W-1:0] c_STV_MAX = c_STV_W'(STARVE_LIMIT);
    logic [c_STV_W-1:0] r_starve;

    assign w_pick_sw = sw_req_i && (!hw_req_i || (r_starve == c_STV_MAX));

    // Counts hw grants taken while sw is kept waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (!sw_req_i || (w_issue && r_owner)) begin
            r_starve <= '0;
        end else if (w_issue && (r_starve != c_STV_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        hw_gnt_o    = 1'b0;
        sw_gnt_o    = 1'b0;
        hw_rvalid_o = 1'b0;
        sw_rvalid_o = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        err_idx_o   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arb) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                hw_gnt_o  = !r_owner;
                sw_gnt_o  = r_owner;
                err_idx_o = w_oob;
                if (!w_oob) begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = r_we;
                    mem_addr_o  = r_index;
                    mem_wdata_o = r_wdata;
                end
                w_state_nxt = (r_we || w_oob) ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (r_lat == 2'd0) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                hw_rvalid_o = !r_owner;
                sw_rvalid_o = r_owner;
                w_state_nxt = w_arb ? S_ISSUE : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= 1'b0;
            r_we    <= 1'b0;
            r_index <= '0;
            r_wdata <= '0;
            r_lat   <= 2'd0;
        end else begin
            if (w_arb) begin
                r_owner <= w_pick_sw;
                r_we    <= w_pick_sw ? sw_we_i    : hw_we_i;
                r_index <= w_pick_sw ? sw_index_i : hw_index_i;
                r_wdata <= w_pick_sw ? sw_wdata_i : hw_wdata_i;
            end
            if (w_issue) begin
                r_lat <= c_LAT_INIT;
            end else if ((r_state == S_WAIT) && (r_lat != 2'd0)) begin
                r_lat <= r_lat - 2'd1;
            end
        end
    end

    // Each requester's read data holds until its own next read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hw_rdata <= '0;
            r_sw_rdata <= '0;
        end else begin
            if (w_issue && w_oob && !r_we) begin
                if (r_owner) r_sw_rdata <= '0;
                else         r_hw_rdata <= '0;
            end
            if (w_capture) begin
                if (r_owner) r_sw_rdata <= mem_rdata_i;
                else         r_hw_rdata <= mem_rdata_i;
            end
        end
    end

    assign hw_rdata_o = r_hw_rdata;
    assign sw_rdata_o = r_sw_rdata;
    assign busy_o     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i3c_table_arbiter.sv
`default_nettype none
// Bench for i3c_table_arbiter: instance A uses default parameters, instance B
// uses DEPTH=24 / MEM_LATENCY=3; completions are checked against a queue.
module tb_i3c_table_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]       hw_req, hw_we, sw_req, sw_we;
    logic [1:0][4:0]  hw_idx, sw_idx;
    logic [1:0][63:0] hw_wd, sw_wd;

    logic        hw_gnt_a, hw_rv_a, sw_gnt_a, sw_rv_a, mem_req_a, mem_we_a, busy_a, err_a;
    logic [4:0]  mem_addr_a;
    logic [63:0] hw_rd_a, sw_rd_a, mem_wd_a, mem_rd_a;
    logic        hw_gnt_b, hw_rv_b, sw_gnt_b, sw_rv_b, mem_req_b, mem_we_b, busy_b, err_b;
    logic [4:0]  mem_addr_b;
    logic [63:0] hw_rd_b, sw_rd_b, mem_wd_b, mem_rd_b;

    i3c_table_arbiter u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .hw_req_i(hw_req[0]), .hw_we_i(hw_we[0]), .hw_index_i(hw_idx[0]), .hw_wdata_i(hw_wd[0]),
        .hw_gnt_o(hw_gnt_a), .hw_rvalid_o(hw_rv_a), .hw_rdata_o(hw_rd_a),
        .sw_req_i(sw_req[0]), .sw_we_i(sw_we[0]), .sw_index_i(sw_idx[0]), .sw_wdata_i(sw_wd[0]),
        .sw_gnt_o(sw_gnt_a), .sw_rvalid_o(sw_rv_a), .sw_rdata_o(sw_rd_a),
        .mem_req_o(mem_req_a), .mem_we_o(mem_we_a), .mem_addr_o(mem_addr_a),
        .mem_wdata_o(mem_wd_a), .mem_rdata_i(mem_rd_a), .busy_o(busy_a), .err_idx_o(err_a)
    );

    i3c_table_arbiter #(.DEPTH(24), .MEM_LATENCY(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .hw_req_i(hw_req[1]), .hw_we_i(hw_we[1]), .hw_index_i(hw_idx[1]), .hw_wdata_i(hw_wd[1]),
        .hw_gnt_o(hw_gnt_b), .hw_rvalid_o(hw_rv_b), .hw_rdata_o(hw_rd_b),
        .sw_req_i(sw_req[1]), .sw_we_i(sw_we[1]), .sw_index_i(sw_idx[1]), .sw_wdata_i(sw_wd[1]),
        .sw_gnt_o(sw_gnt_b), .sw_rvalid_o(sw_rv_b), .sw_rdata_o(sw_rd_b),
        .mem_req_o(mem_req_b), .mem_we_o(mem_we_b), .mem_addr_o(mem_addr_b),
        .mem_wdata_o(mem_wd_b), .mem_rdata_i(mem_rd_b), .busy_o(busy_b), .err_idx_o(err_b)
    );

    wire [1:0]       hw_gnt = {hw_gnt_b, hw_gnt_a};
    wire [1:0]       sw_gnt = {sw_gnt_b, sw_gnt_a};
    wire [1:0]       m_req  = {mem_req_b, mem_req_a};
    wire [1:0]       m_we   = {mem_we_b, mem_we_a};
    wire [1:0]       busy   = {busy_b, busy_a};
    wire [1:0]       err    = {err_b, err_a};
    wire [1:0][4:0]  m_addr = {mem_addr_b, mem_addr_a};
    wire [1:0][63:0] m_wd   = {mem_wd_b, mem_wd_a};
    wire [3:0]       rv     = {sw_rv_b, hw_rv_b, sw_rv_a, hw_rv_a};
    wire [3:0][63:0] rd_all = {sw_rd_b, hw_rd_b, sw_rd_a, hw_rd_a};

    // Table model: entry k starts as DEAD_BEEF_0000_000k; non-read cycles return noise.
    for (genvar gi = 0; gi < 2; gi++) begin : g_mem
        logic [63:0] mem [32];
        logic [63:0] pipe [3];
        initial for (int k = 0; k < 32; k++) mem[k] <= {32'hDEAD_BEEF, 32'(k)};
        always @(posedge clk) begin
            if (m_req[gi] && m_we[gi]) mem[m_addr[gi]] <= m_wd[gi];
            pipe[0] <= (m_req[gi] && !m_we[gi]) ? mem[m_addr[gi]] : {$urandom(), $urandom()};
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
    end
    assign mem_rd_a = g_mem[0].pipe[0];
    assign mem_rd_b = g_mem[1].pipe[2];

    typedef struct {
        int          port;   // instance*2 + (sw ? 1 : 0)
        logic [63:0] data;
        int          cyc;
    } exp_t;
    exp_t        q[$];
    logic [63:0] model_rd [4];

    task automatic push_exp(input int p, input bit is_rd, input logic [63:0] d, input int c);
        if (is_rd) model_rd[p] = d;
        q.push_back('{p, model_rd[p], c});
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int p = 0; p < 4; p++) begin
            if (rv[p]) begin
                n_tests++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rvalid port=%0d cyc=%0d data=%h", p, cyc, rd_all[p]);
                end else begin
                    e = q.pop_front();
                    if (e.port != p || e.cyc != cyc || rd_all[p] !== e.data) begin
                        n_fail++;
                        $display("FAIL completion: got port=%0d cyc=%0d data=%h, want port=%0d cyc=%0d data=%h",
                                 p, cyc, rd_all[p], e.port, e.cyc, e.data);
                    end
                end
            end
        end
    end

    task automatic access(input int b, input bit sw, input bit we, input int idx,
                          input logic [63:0] wd, input logic [63:0] exp_rd,
                          input int dly, input bit oob, output int t_gnt);
        int p;
        p     = b * 2 + (sw ? 1 : 0);
        t_gnt = -1;
        if (sw) begin sw_req[b] = 1'b1; sw_we[b] = we; sw_idx[b] = 5'(idx); sw_wd[b] = wd; end
        else    begin hw_req[b] = 1'b1; hw_we[b] = we; hw_idx[b] = 5'(idx); hw_wd[b] = wd; end
        for (int k = 0; k < 40 && t_gnt < 0; k++) begin
            @(negedge clk);
            if (sw ? sw_gnt[b] : hw_gnt[b]) t_gnt = cyc;
        end
        if (sw) sw_req[b] = 1'b0; else hw_req[b] = 1'b0;
        n_tests++;
        if (t_gnt < 0) begin
            n_fail++;
            $display("FAIL gnt_timeout port=%0d idx=%0d: no grant within 40 cycles", p, idx);
            return;
        end
        push_exp(p, !we, exp_rd, t_gnt + dly);
        n_tests++;
        if (m_req[b] !== !oob || err[b] !== oob || busy[b] !== 1'b1 ||
            (!oob && (m_addr[b] !== 5'(idx) || m_we[b] !== we))) begin
            n_fail++;
            $display("FAIL issue_cycle port=%0d: got req=%b err=%b busy=%b addr=%0d we=%b, want req=%b err=%b busy=1 addr=%0d we=%b",
                     p, m_req[b], err[b], busy[b], m_addr[b], m_we[b], !oob, oob, idx, we);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hw_req = '0; hw_we = '0; hw_idx = '0; hw_wd = '0;
        sw_req = '0; sw_we = '0; sw_idx = '0; sw_wd = '0;
        for (int p = 0; p < 4; p++) model_rd[p] = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({hw_gnt_a, hw_rv_a, sw_gnt_a, sw_rv_a, mem_req_a, mem_we_a, busy_a, err_a} !== 8'd0 ||
            hw_rd_a !== 64'd0 || sw_rd_a !== 64'd0 || mem_addr_a !== 5'd0 || mem_wd_a !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ctl=%b hw_rd=%h sw_rd=%h, want all zero",
                     {hw_gnt_a, hw_rv_a, sw_gnt_a, sw_rv_a, mem_req_a, mem_we_a, busy_a, err_a}, hw_rd_a, sw_rd_a);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b%b, want 00", busy_b, busy_a);
        end
    endtask

    task automatic test_hw_read();
        int t;
        access(0, 0, 0, 5, 64'd0, 64'hDEAD_BEEF_0000_0005, 2, 0, t);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int t1, t2;
        access(0, 1, 1, 3, 64'h1234, 64'd0, 1, 0, t1);
        access(0, 1, 0, 3, 64'd0, 64'h1234, 2, 0, t2);
        n_tests++;
        if (t2 != t1 + 2) begin
            n_fail++;
            $display("FAIL b2b_gap: got read grant %0d cycles after write grant, want 2", t2 - t1);
        end
        repeat (4) @(negedge clk);
        n_tests++;
        if (hw_rd_a !== 64'hDEAD_BEEF_0000_0005) begin
            n_fail++;
            $display("FAIL hw_rdata_hold: got %h, want %h", hw_rd_a, 64'hDEAD_BEEF_0000_0005);
        end
    endtask

    task automatic test_contention();
        int t, th, ts;
        access(0, 0, 0, 1, 64'd0, 64'hDEAD_BEEF_0000_0001, 2, 0, t);
        repeat (4) @(negedge clk);
        hw_we[0] = 1'b0; hw_idx[0] = 5'd2; hw_req[0] = 1'b1;
        sw_we[0] = 1'b0; sw_idx[0] = 5'd4; sw_req[0] = 1'b1;
        th = -1; ts = -1;
        for (int k = 0; k < 30 && (th < 0 || ts < 0); k++) begin
            @(negedge clk);
            if (hw_gnt_a) begin th = cyc; hw_req[0] = 1'b0; push_exp(0, 1, 64'hDEAD_BEEF_0000_0002, cyc + 2); end
            if (sw_gnt_a) begin ts = cyc; sw_req[0] = 1'b0; push_exp(1, 1, 64'hDEAD_BEEF_0000_0004, cyc + 2); end
        end
        n_tests++;
`ifdef I3C_TABLE_ARB_RR_EN
        if (ts < 0 || th != ts + 3) begin
            n_fail++;
            $display("FAIL contention_rr: got sw_gnt=%0d hw_gnt=%0d, want hw 3 cycles after sw", ts, th);
        end
`else
        if (th < 0 || ts != th + 3) begin
            n_fail++;
            $display("FAIL contention: got hw_gnt=%0d sw_gnt=%0d, want sw 3 cycles after hw", th, ts);
        end
`endif
        repeat (4) @(negedge clk);
    endtask

    task automatic test_starvation();
        logic [6:0] got, want;
        int ng, nh;
        got = '0; ng = 0; nh = 0;
`ifdef I3C_TABLE_ARB_RR_EN
        want = 7'b000_0001;
`else
        want = 7'b001_0000;
`endif
        hw_we[0] = 1'b0; hw_idx[0] = 5'd10; hw_req[0] = 1'b1;
        sw_we[0] = 1'b0; sw_idx[0] = 5'd20; sw_req[0] = 1'b1;
        for (int k = 0; k < 60 && ng < 7; k++) begin
            @(negedge clk);
            if (hw_gnt_a) begin
                got[ng] = 1'b0; ng++;
                push_exp(0, 1, {32'hDEAD_BEEF, 32'(10 + nh)}, cyc + 2);
                nh++;
                if (nh < 6) hw_idx[0] = 5'(10 + nh);
                else        hw_req[0] = 1'b0;
            end
            if (sw_gnt_a) begin
                got[ng] = 1'b1; ng++;
                push_exp(1, 1, 64'hDEAD_BEEF_0000_0014, cyc + 2);
                sw_req[0] = 1'b0;
            end
        end
        hw_req[0] = 1'b0; sw_req[0] = 1'b0;
        n_tests++;
        if (ng != 7 || got !== want) begin
            n_fail++;
            $display("FAIL grant_order: got %0d grants order=%b (bit i=1 means sw), want 7 grants order=%b", ng, got, want);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_out_of_range();
        int t;
        access(1, 0, 0, 6, 64'd0, 64'hDEAD_BEEF_0000_0006, 4, 0, t);
        repeat (6) @(negedge clk);
        access(1, 0, 0, 30, 64'd0, 64'd0, 1, 1, t);
        access(1, 0, 0, 7, 64'd0, 64'hDEAD_BEEF_0000_0007, 4, 0, t);
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        int t;
        t = -1;
        hw_we[0] = 1'b0; hw_idx[0] = 5'd9; hw_req[0] = 1'b1;
        for (int k = 0; k < 40 && t < 0; k++) begin
            @(negedge clk);
            if (hw_gnt_a) t = cyc;
        end
        hw_req[0] = 1'b0;
        n_tests++;
        if (t < 0) begin
            n_fail++;
            $display("FAIL mid_reset_gnt_timeout: no grant within 40 cycles");
        end
        @(negedge clk);
        n_tests++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_in_wait: got %b, want 1", busy_a);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({hw_gnt_a, hw_rv_a, sw_gnt_a, sw_rv_a, mem_req_a, busy_a, err_a} !== 7'd0 ||
            hw_rd_a !== 64'd0 || sw_rd_a !== 64'd0) begin
            n_fail++;
            $display("FAIL async_reset: got ctl=%b hw_rd=%h sw_rd=%h, want all zero",
                     {hw_gnt_a, hw_rv_a, sw_gnt_a, sw_rv_a, mem_req_a, busy_a, err_a}, hw_rd_a, sw_rd_a);
        end
        for (int p = 0; p < 4; p++) model_rd[p] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        n_tests++;
        if (busy_a !== 1'b0 || hw_rd_a !== 64'd0) begin
            n_fail++;
            $display("FAIL after_reset_release: got busy=%b hw_rd=%h, want busy=0 hw_rd=0", busy_a, hw_rd_a);
        end
    endtask

    initial begin
        test_reset();
        test_hw_read();
        test_back_to_back();
        test_contention();
        test_starvation();
        test_out_of_range();
        test_reset_mid_access();
        n_tests++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_completions: got %0d outstanding, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
